decode_issue_buffer: RTL and testbench

- Producer side of the decode-to-execute interface. Accepts fully decoded instructions from the decoder: register operands, immediate, `control_type` bundle, compare flag and PC.
- Buffers them in a small FIFO and presents them to the execute stage with a valid/ready handshake.
- Absorbs execute back-pressure and supports pipeline flush on branch redirect.

---
 rtl/decode_issue_buffer_pkg.sv | 16 +
 rtl/decode_issue_buffer.sv | 133 +++++++++++++
 tb/tb_decode_issue_buffer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_buffer_pkg.sv
// Shared decode-stage types: the decoded control bundle handed from decode to execute.
// An all-zero control_type is the NOP bubble.
package decode_issue_buffer_pkg;

  typedef struct packed {
    logic [3:0] aluOp;
    logic       aluSrc;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       branch;
    logic       jump;
    logic [1:0] wbSel;
  } control_type;

endpackage

// File: rtl/decode_issue_buffer.sv
// Decode-to-execute issue FIFO with valid/ready handshake, back-pressure and flush.
// Optional macro DECODE_ISSUE_STATS_EN adds saturating stall/bubble/flush counters.
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_data1,
  input  logic [XLEN-1:0]              in_data2,
  input  logic [XLEN-1:0]              in_immediate,
  input  control_type                  in_control,
  input  logic                         in_compflg,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         ex_valid,
  input  logic                         ex_ready,
  output logic [XLEN-1:0]              ex_data1,
  output logic [XLEN-1:0]              ex_data2,
  output logic [XLEN-1:0]              ex_immediate_data,
  output control_type                  ex_control,
  output logic                         ex_compflg,
  output logic [XLEN-1:0]              ex_program_counter,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef DECODE_ISSUE_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  bubble_cycles,
  output logic [31:0]                  flush_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] immediate;
    control_type     control;
    logic            compflg;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  entry_t          w_inEntry;
  entry_t          w_head;

  // in_ready depends on the count alone, so a full buffer refuses a push even when the head pops.
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != CW'(DEPTH));
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = !w_empty && ex_ready && !flush;

  assign w_inEntry.data1     = in_data1;
  assign w_inEntry.data2     = in_data2;
  assign w_inEntry.immediate = in_immediate;
  assign w_inEntry.control   = in_control;
  assign w_inEntry.compflg   = in_compflg;
  assign w_inEntry.pc        = in_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (flush) begin
      r_count <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  // Payload storage needs no reset: it is only observed through the count-qualified head mux.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_inEntry;
  end

  assign w_head = w_empty ? '0 : r_mem[r_rdPtr];

  assign ex_valid           = !w_empty;
  assign ex_data1           = w_head.data1;
  assign ex_data2           = w_head.data2;
  assign ex_immediate_data  = w_head.immediate;
  assign ex_control         = w_head.control;
  assign ex_compflg         = w_head.compflg;
  assign ex_program_counter = w_head.pc;
  assign occupancy          = r_count;

`ifdef DECODE_ISSUE_STATS_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_bubbleCycles;
  logic [31:0] r_flushCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles  <= '0;
      r_bubbleCycles <= '0;
      r_flushCount   <= '0;
    end else begin
      if (in_valid && !in_ready && (r_stallCycles != '1))
        r_stallCycles <= r_stallCycles + 32'd1;
      if (ex_ready && w_empty && (r_bubbleCycles != '1))
        r_bubbleCycles <= r_bubbleCycles + 32'd1;
      if (flush && (r_flushCount != '1))
        r_flushCount <= r_flushCount + 32'd1;
    end
  end

  assign stall_cycles  = r_stallCycles;
  assign bubble_cycles = r_bubbleCycles;
  assign flush_count   = r_flushCount;
`endif

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Scoreboard bench for decode_issue_buffer: directed scenarios plus randomized traffic,
// checked against a queue model of the buffer contents.
module tb_decode_issue_buffer;
  import decode_issue_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] immediate;
    control_type     control;
    logic            compflg;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_data1 = '0;
  logic [XLEN-1:0] in_data2 = '0;
  logic [XLEN-1:0] in_immediate = '0;
  control_type     in_control = '0;
  logic            in_compflg = 1'b0;
  logic [XLEN-1:0] in_pc = '0;
  logic            ex_valid;
  logic            ex_ready = 1'b0;
  logic [XLEN-1:0] ex_data1;
  logic [XLEN-1:0] ex_data2;
  logic [XLEN-1:0] ex_immediate_data;
  control_type     ex_control;
  logic            ex_compflg;
  logic [XLEN-1:0] ex_program_counter;
  logic [CW-1:0]   occupancy;
`ifdef DECODE_ISSUE_STATS_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     bubble_cycles;
  logic [31:0]     flush_count;
`endif

  decode_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data1           (in_data1),
    .in_data2           (in_data2),
    .in_immediate       (in_immediate),
    .in_control         (in_control),
    .in_compflg         (in_compflg),
    .in_pc              (in_pc),
    .ex_valid           (ex_valid),
    .ex_ready           (ex_ready),
    .ex_data1           (ex_data1),
    .ex_data2           (ex_data2),
    .ex_immediate_data  (ex_immediate_data),
    .ex_control         (ex_control),
    .ex_compflg         (ex_compflg),
    .ex_program_counter (ex_program_counter),
    .occupancy          (occupancy)
`ifdef DECODE_ISSUE_STATS_EN
    ,
    .stall_cycles       (stall_cycles),
    .bubble_cycles      (bubble_cycles),
    .flush_count        (flush_count)
`endif
  );

  always #5 clk = ~clk;

  entry_t      expq[$];
  int          checkCount = 0;
  int          errorCount = 0;
  bit          monEnable = 1'b0;
  int unsigned mStall = 0;
  int unsigned mBubble = 0;
  int unsigned mFlush = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic entry_t mkEntry(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] d1);
    entry_t e;
    logic [$bits(control_type)-1:0] cb;
    cb          = $bits(control_type)'($urandom);
    e.data1     = d1;
    e.data2     = $urandom;
    e.immediate = $urandom;
    e.control   = control_type'(cb);
    e.compflg   = 1'($urandom);
    e.pc        = pc;
    return e;
  endfunction

  // Drives one cycle of inputs just after the edge, then records the expected effect in the model.
  task automatic applyStimulus(input logic v, input entry_t e, input logic rdy, input logic fl);
    int sz;
    @(posedge clk);
    #1;
    in_valid     = v;
    in_data1     = e.data1;
    in_data2     = e.data2;
    in_immediate = e.immediate;
    in_control   = e.control;
    in_compflg   = e.compflg;
    in_pc        = e.pc;
    ex_ready     = rdy;
    flush        = fl;
    sz           = expq.size();
    #2;
    if (v && sz >= DEPTH && mStall != 32'hFFFF_FFFF) mStall++;
    if (rdy && sz == 0 && mBubble != 32'hFFFF_FFFF) mBubble++;
    if (fl) begin
      expq.delete();
      if (mFlush != 32'hFFFF_FFFF) mFlush++;
    end else if (v && sz < DEPTH) begin
      expq.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, mkEntry('0, '0), rdy, 1'b0);
  endtask

  // Asynchronous reset dropped mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic doReset();
    monEnable = 1'b0;
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_ex_valid", 64'(ex_valid), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_occupancy", 64'(occupancy), 64'(0));
    checkOutput("reset_ex_control", 64'(ex_control), 64'(0));
    checkOutput("reset_ex_pc", 64'(ex_program_counter), 64'(0));
    expq.delete();
    mStall = 0;
    mBubble = 0;
    mFlush = 0;
    in_valid = 1'b0;
    ex_ready = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    monEnable = 1'b1;
  endtask

  // Monitor: compares status and head against the model, retires the head on a handshake.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (monEnable) begin
        checkOutput("occupancy", 64'(occupancy), 64'(expq.size()));
        checkOutput("in_ready", 64'(in_ready), 64'(expq.size() < DEPTH));
        checkOutput("ex_valid", 64'(ex_valid), 64'(expq.size() > 0));
        if (expq.size() == 0) begin
          checkOutput("empty_ex_control", 64'(ex_control), 64'(0));
          checkOutput("empty_ex_data1", 64'(ex_data1), 64'(0));
          checkOutput("empty_ex_pc", 64'(ex_program_counter), 64'(0));
        end else begin
          checkOutput("head_data1", 64'(ex_data1), 64'(expq[0].data1));
          checkOutput("head_data2", 64'(ex_data2), 64'(expq[0].data2));
          checkOutput("head_imm", 64'(ex_immediate_data), 64'(expq[0].immediate));
          checkOutput("head_control", 64'(ex_control), 64'(expq[0].control));
          checkOutput("head_compflg", 64'(ex_compflg), 64'(expq[0].compflg));
          checkOutput("head_pc", 64'(ex_program_counter), 64'(expq[0].pc));
          if (ex_ready && !flush) void'(expq.pop_front());
        end
`ifdef DECODE_ISSUE_STATS_EN
        checkOutput("stall_cycles", 64'(stall_cycles), 64'(mStall));
        checkOutput("bubble_cycles", 64'(bubble_cycles), 64'(mBubble));
        checkOutput("flush_count", 64'(flush_count), 64'(mFlush));
`endif
      end
    end
  end

  initial begin
    doReset();

    // Single push with execute ready
    applyStimulus(1'b1, mkEntry(32'h0000_0040, 32'h1234_5678), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill under back-pressure, third push held until space frees
    applyStimulus(1'b1, mkEntry(32'h00, $urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, mkEntry(32'h04, $urandom), 1'b0, 1'b0);
    begin
      entry_t e8;
      e8 = mkEntry(32'h08, $urandom);
      applyStimulus(1'b1, e8, 1'b0, 1'b0);
      applyStimulus(1'b1, e8, 1'b1, 1'b0);
      applyStimulus(1'b1, e8, 1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Steady stream
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, mkEntry(32'(i * 4), $urandom), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush with a coinciding push
    applyStimulus(1'b1, mkEntry(32'h10, $urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, mkEntry(32'h14, $urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, mkEntry(32'h20, $urandom), 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Reset while full
    applyStimulus(1'b1, mkEntry(32'h30, $urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, mkEntry(32'h34, $urandom), 1'b0, 1'b0);
    doReset();

`ifdef DECODE_ISSUE_STATS_EN
    applyStimulus(1'b1, mkEntry(32'h40, $urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, mkEntry(32'h44, $urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, mkEntry(32'h48, $urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, mkEntry('0, '0), 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("stats_stall_total", 64'(stall_cycles), 64'(5));
    checkOutput("stats_flush_total", 64'(flush_count), 64'(1));
    doReset();
`endif

    // Randomized traffic with occasional flush and mid-run resets
    for (int i = 0; i < 1500; i++) begin
      if (i % 400 == 399) doReset();
      applyStimulus(($urandom_range(0, 9) < 7), mkEntry($urandom, $urandom),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
    end
    idle(1'b1);
    idle(1'b1);

    monEnable = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, errorCount);
    $finish;
  end

endmodule
